nibble_tx: RTL and testbench

- Parallel-in, serial-out frame transmitter.
- It is the read side of the team's parallel register path. It takes a WIDTH-bit word over a valid/ready handshake and shifts it out on one line.
- Frame format: start bit (0), data bits LSB first, stop bit (1). Every bit is held for CLKS_PER_BIT clocks.
- It sits in the fsm block group and drives an external serial link or a matching serial-to-parallel register.

---
 rtl/nibble_tx_pkg.sv | 16 +
 rtl/nibble_tx_bit_timer.sv | 28 ++
 rtl/nibble_tx.sv | 113 +++++++++++
 tb/tb_nibble_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_tx_pkg.sv
// Shared definitions for the nibble_tx serial frame transmitter:
// FSM state encoding and serial line levels.
package nibble_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/nibble_tx_bit_timer.sv
// Per-bit cycle counter for nibble_tx; tick marks the last clock of each serial bit.
// Counter is held at zero whenever run is low or enable (active-low reset) is low.
module bit_timer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clock,
  input  logic enable,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  // Wrapping on tick keeps the count aligned to bit boundaries across state changes.
  always_ff @(posedge clock) begin
    if (!enable || !run || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nibble_tx.sv
// Parallel-in, serial-out frame transmitter: start(0), data LSB first, stop(1).
// Define NIBBLE_TX_PARITY_EN to insert an even-parity bit between data and stop.
module nibble_tx
  import nibble_tx_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic             clock,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic [BW-1:0]    bit_idx;
  logic             run;
  logic             tick;
`ifdef NIBBLE_TX_PARITY_EN
  logic             parity;
`endif

  assign in_ready   = (state == ST_IDLE);
  assign busy       = ~in_ready;
  assign run        = (state != ST_IDLE);
  assign shift_next = shift >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock (clock),
    .enable(enable),
    .run   (run),
    .tick  (tick)
  );

  // tx is registered: each transition loads the line level of the state being entered.
  always_ff @(posedge clock) begin
    if (!enable) begin
      state   <= ST_IDLE;
      tx      <= LINE_IDLE;
      shift   <= '0;
      bit_idx <= '0;
`ifdef NIBBLE_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shift <= in_data;
            state <= ST_START;
            tx    <= LINE_START;
`ifdef NIBBLE_TX_PARITY_EN
            parity <= ^in_data;
`endif
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
`ifdef NIBBLE_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= parity;
`else
              state <= ST_STOP;
              tx    <= LINE_IDLE;
`endif
            end else begin
              shift   <= shift_next;
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift_next[0];
            end
          end
        end
`ifdef NIBBLE_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            tx    <= LINE_IDLE;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            state <= ST_IDLE;
            tx    <= LINE_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_tx.sv
// Directed self-checking bench for nibble_tx (WIDTH=4/CLKS_PER_BIT=2 and WIDTH=1/CLKS_PER_BIT=1).
module tb_nibble_tx;

  localparam int W   = 4;
  localparam int CPB = 2;
`ifdef NIBBLE_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL  = (W + 2 + PAR) * CPB;
  localparam int FL1 = (1 + 2 + PAR);

  logic         clock = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, tx, busy;
  logic [0:0]   in_data1 = '0;
  logic         in_valid1 = 1'b0;
  logic         in_ready1, tx1, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  nibble_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .enable  (enable),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy)
  );

  nibble_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clock   (clock),
    .enable  (enable),
    .in_data (in_data1),
    .in_valid(in_valid1),
    .in_ready(in_ready1),
    .tx      (tx1),
    .busy    (busy1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected line level k cycles after the accept edge, from the frame format.
  function automatic logic exp_bit(input logic [W-1:0] word, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= W) return word[slot-1];
    if (PAR == 1 && slot == W + 1) return ^word;
    return 1'b1;
  endfunction

  task automatic check_idle(input string name);
    checks++;
    if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s tx/in_ready/busy got=%b%b%b exp=110", name, tx, in_ready, busy);
    end
  endtask

  task automatic check_frame(input logic [W-1:0] word, input string name,
                             input int chg_at, input logic [W-1:0] chg_val);
    for (int k = 0; k < FL; k++) begin
      if (k == chg_at) in_data = chg_val;
      checks++;
      if (tx !== exp_bit(word, k)) begin
        failures++;
        $display("[TB] FAIL %s tx[%0d] got=%b exp=%b", name, k, tx, exp_bit(word, k));
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s busy/in_ready[%0d] got=%b%b exp=10", name, k, busy, in_ready);
      end
      step();
    end
    check_idle({name, "_end"});
  endtask

  task automatic test_reset();
    enable    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hA;
    in_valid1 = 1'b1;
    in_data1  = 1'b1;
    step();
    step();
    check_idle("reset_hold");
    checks++;
    if (tx1 !== 1'b1 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold_w1 tx/in_ready/busy got=%b%b%b exp=110", tx1, in_ready1, busy1);
    end
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    enable    = 1'b1;
    step();
    check_idle("reset_release");
  endtask

  task automatic test_single_frame();
    in_data  = 4'b1010;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_frame(4'b1010, "single", -1, '0);
  endtask

  task automatic test_back_to_back();
    in_data  = 4'hF;
    in_valid = 1'b1;
    step();
    check_frame(4'hF, "b2b_first", -1, '0);
    in_data = 4'h0;
    step();
    in_valid = 1'b0;
    check_frame(4'h0, "b2b_second", -1, '0);
  endtask

  task automatic test_data_stability();
    in_data  = 4'h3;
    in_valid = 1'b1;
    step();
    check_frame(4'h3, "stable", 5, 4'hC);
    step();
    in_valid = 1'b0;
    check_frame(4'hC, "stable_next", -1, '0);
  endtask

  task automatic test_reset_mid_frame();
    in_data  = 4'h6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3 * CPB; k++) step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_bit2 tx/busy got=%b%b exp=11", tx, busy);
    end
    enable = 1'b0;
    step();
    check_idle("midreset_abort");
    enable = 1'b1;
    step();
    check_idle("midreset_no_stop");
    in_data  = 4'h5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_frame(4'h5, "after_reset", -1, '0);
  endtask

  task automatic test_edge_params();
    logic exp;
    in_data1  = 1'b1;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    for (int k = 0; k < FL1; k++) begin
      exp = (k == 0) ? 1'b0 : 1'b1;
      checks++;
      if (tx1 !== exp || busy1 !== 1'b1) begin
        failures++;
        $display("[TB] FAIL w1 tx/busy[%0d] got=%b%b exp=%b1", k, tx1, busy1, exp);
      end
      step();
    end
    checks++;
    if (tx1 !== 1'b1 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL w1_end tx/in_ready/busy got=%b%b%b exp=110", tx1, in_ready1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
    test_edge_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
